// File: rtl/qu_pkg.sv
// Shared core package: default register-file sizes and the physical register
// index type used by rename-stage blocks.
package qu_pkg;

  localparam int QU_PHY_RF_DEPTH  = 128;
  localparam int QU_ARCH_RF_DEPTH = 32;

  typedef logic [$clog2(QU_PHY_RF_DEPTH)-1:0] phy_reg_t;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of unallocated register indices.
// Optional double-free detection is built with QU_FREE_LIST_DOUBLE_FREE_CHECK_EN.
module free_list
  import qu_pkg::*;
#(
  parameter int PHY_RF_DEPTH  = QU_PHY_RF_DEPTH,
  parameter int ARCH_RF_DEPTH = QU_ARCH_RF_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_req,
  output logic                               alloc_valid,
  output logic [$clog2(PHY_RF_DEPTH)-1:0]    alloc_addr,
  input  logic                               release_en,
  input  logic [$clog2(PHY_RF_DEPTH)-1:0]    release_addr,
  output logic [$clog2(PHY_RF_DEPTH-ARCH_RF_DEPTH+1)-1:0] free_count,
  output logic                               err_flag
);

  localparam int N  = PHY_RF_DEPTH - ARCH_RF_DEPTH;
  localparam int AW = $clog2(PHY_RF_DEPTH);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] COUNT_FULL = CW'(N);
  localparam logic [PW-1:0] PTR_LAST   = PW'(N - 1);

  logic [AW-1:0] entries [N];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic pop;
  logic push;
  logic bad_addr;

  // Capacity need not be a power of two, so the pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign alloc_valid = (count != '0);
  assign alloc_addr  = entries[head];
  assign free_count  = count;
  assign pop         = alloc_req && alloc_valid;

`ifdef QU_FREE_LIST_DOUBLE_FREE_CHECK_EN
  localparam logic [AW-1:0] ARCH_LIMIT = AW'(ARCH_RF_DEPTH);

  logic [PHY_RF_DEPTH-1:0] in_list;

  assign bad_addr = in_list[release_addr] || (release_addr < ARCH_LIMIT);

  // The head entry still counts as held in the cycle it is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_RF_DEPTH; i++) begin
        in_list[i] <= (i >= ARCH_RF_DEPTH);
      end
    end else begin
      if (pop) begin
        in_list[entries[head]] <= 1'b0;
      end
      if (push) begin
        in_list[release_addr] <= 1'b1;
      end
    end
  end
`else
  assign bad_addr = 1'b0;
`endif

  // A release into a full list is accepted only when a pop frees a slot.
  assign push = release_en && !bad_addr && ((count != COUNT_FULL) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        entries[i] <= AW'(ARCH_RF_DEPTH + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= COUNT_FULL;
      err_flag <= 1'b0;
    end else begin
      if (pop) begin
        head <= ptr_next(head);
      end
      if (push) begin
        entries[tail] <= release_addr;
        tail          <= ptr_next(tail);
      end
      case ({pop, push})
        2'b10:   count <= count - 1'b1;
        2'b01:   count <= count + 1'b1;
        default: count <= count;
      endcase
      if (release_en && !push) begin
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues expected outputs, a monitor
// compares them on the falling edge. Honours QU_FREE_LIST_DOUBLE_FREE_CHECK_EN.
module tb_free_list;
  import qu_pkg::*;

  localparam int N = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  phy_reg_t   alloc_addr;
  logic       release_en;
  phy_reg_t   release_addr;
  logic [6:0] free_count;
  logic       err_flag;

  typedef struct {
    string      tag;
    logic       valid;
    phy_reg_t   addr;
    logic [6:0] cnt;
    logic       err;
  } exp_t;

  exp_t     sb[$];
  exp_t     cur;
  phy_reg_t mq[$];
  phy_reg_t held[$];
  logic     merr;
  int       total = 0;
  int       bad = 0;

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_addr   (alloc_addr),
    .release_en   (release_en),
    .release_addr (release_addr),
    .free_count   (free_count),
    .err_flag     (err_flag)
  );

  always #5 clk = ~clk;

  // Monitor: outputs depend only on state, so every queued expectation is
  // checked mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      total++;
      if (alloc_valid !== cur.valid || free_count !== cur.cnt || err_flag !== cur.err ||
          (cur.valid && alloc_addr !== cur.addr)) begin
        bad++;
        $display("FAIL %s: got valid=%b addr=%0d count=%0d err=%b, need valid=%b addr=%0d count=%0d err=%b",
                 cur.tag, alloc_valid, alloc_addr, free_count, err_flag,
                 cur.valid, cur.addr, cur.cnt, cur.err);
      end
    end
  end

  task automatic push_exp(string tag, logic v, phy_reg_t a, logic [6:0] c, logic e);
    exp_t x;
    x.tag = tag; x.valid = v; x.addr = a; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic push_model(string tag);
    push_exp(tag, mq.size() != 0, (mq.size() != 0) ? mq[0] : '0, 7'(mq.size()), merr);
  endtask

  function automatic bit in_model(phy_reg_t a);
    foreach (mq[i]) if (mq[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; alloc_req = 1'b1; release_en = 1'b1; release_addr = 7'd5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; alloc_req = 1'b0; release_en = 1'b0;
    mq.delete();
    for (int i = 0; i < N; i++) mq.push_back(phy_reg_t'(32 + i));
    merr = 1'b0;
    push_exp("reset", 1'b1, 7'd32, 7'd96, 1'b0);
  endtask

  // One clock of stimulus followed by the reference model update.
  task automatic step(logic req, logic rel, phy_reg_t ra, string tag);
    bit pop, dbl, push;
    alloc_req = req; release_en = rel; release_addr = ra;
    @(posedge clk);
    #1;
    pop = req && (mq.size() != 0);
    dbl = 1'b0;
`ifdef QU_FREE_LIST_DOUBLE_FREE_CHECK_EN
    dbl = rel && ((ra < 7'd32) || in_model(ra));
`endif
    push = rel && !dbl && ((mq.size() != N) || pop);
    if (rel && !push) merr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(ra);
    alloc_req = 1'b0; release_en = 1'b0;
    push_model(tag);
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; release_en = 1'b0; release_addr = '0; merr = 1'b0;
    do_reset();

    step(1, 0, 0, "alloc1"); push_exp("alloc1_hand", 1, 7'd33, 7'd95, 0);
    step(1, 0, 0, "alloc2"); push_exp("alloc2_hand", 1, 7'd34, 7'd94, 0);
    step(1, 0, 0, "alloc3"); push_exp("alloc3_hand", 1, 7'd35, 7'd93, 0);
    for (int i = 0; i < 93; i++) step(1, 0, 0, "drain");
    push_exp("empty_hand", 0, 7'd0, 7'd0, 0);
    step(1, 0, 0, "alloc_empty1");
    step(1, 0, 0, "alloc_empty2");

    step(1, 1, 7'd40, "release_into_empty");
    push_exp("release_visible_hand", 1, 7'd40, 7'd1, 0);

    for (int a = 32; a < 128; a++) if (a != 40) step(0, 1, phy_reg_t'(a), "refill");
    push_exp("refilled_hand", 1, 7'd40, 7'd96, 0);
    step(0, 1, 7'd50, "overflow");
    push_exp("overflow_hand", 1, 7'd40, 7'd96, 1);

    do_reset();
    step(1, 1, 7'd50, "full_pop_push");
`ifdef QU_FREE_LIST_DOUBLE_FREE_CHECK_EN
    push_exp("full_pop_push_hand", 1, 7'd33, 7'd95, 1);
`else
    push_exp("full_pop_push_hand", 1, 7'd33, 7'd96, 0);
`endif

    do_reset();
    step(1, 0, 0, "pre_rel100");
    step(0, 1, 7'd100, "rel100");
`ifdef QU_FREE_LIST_DOUBLE_FREE_CHECK_EN
    push_exp("rel100_hand", 1, 7'd33, 7'd95, 1);
`else
    push_exp("rel100_hand", 1, 7'd33, 7'd96, 0);
`endif

    do_reset();
    step(1, 0, 0, "pre_rel5");
    step(0, 1, 7'd5, "rel5");
`ifdef QU_FREE_LIST_DOUBLE_FREE_CHECK_EN
    push_exp("rel5_hand", 1, 7'd33, 7'd95, 1);
`else
    push_exp("rel5_hand", 1, 7'd33, 7'd96, 0);
`endif

    // Wrap: recycle previously allocated registers so every release is fresh.
    do_reset();
    held.delete();
    for (int i = 0; i < 10; i++) begin
      held.push_back(mq[0]);
      step(1, 0, 0, "wrap_prime");
    end
    for (int i = 0; i < 200; i++) begin
      phy_reg_t popped;
      popped = mq[0];
      step(1, 1, held.pop_front(), "wrap_pair");
      held.push_back(popped);
    end
    for (int i = 0; i < 86; i++) step(1, 0, 0, "wrap_drain");
    push_exp("wrap_empty_hand", 0, 7'd0, 7'd0, 0);

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
